// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter: FSM encoding and
// parameter defaults used by the top and its round-robin picker.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_START = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_t;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Round-robin picker: one-hot grant for the first requester after last_grant,
// wrapping to index 0. Purely combinational.
module uart_tx_arbiter_rr
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [NUM_REQ-1:0] o_grant
);

    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_hi;
    logic [NUM_REQ-1:0] w_pick;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_mask[i] = (i > int'(i_last_grant));
        end
    end

    // Prefer requesters above the last owner; otherwise wrap to the lowest index.
    assign w_hi    = i_req & w_mask;
    assign w_pick  = (|w_hi) ? w_hi : i_req;
    assign o_grant = w_pick & (~w_pick + ONE);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one UART byte transmitter among
// NUM_REQ requesters, with a mid-packet stall watchdog.
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin
// SEND  | owner holds grant; wait for its byte and a free UART
// START | one-cycle tx_start pulse with the latched byte
// DRAIN | wait out busy-rise latency and the UART frame
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]        i_req_last,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [DATA_W-1:0]         o_tx_data,
    output logic                      o_tx_start,
    input  logic                      i_tx_busy,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic [NUM_REQ-1:0]        o_timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDX_W-1:0]   r_grant_idx;
    logic [IDX_W-1:0]   r_last_grant;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic [DATA_W-1:0]  r_tx_data;
    logic               r_last_q;
    logic               r_drain_first;
    logic [NUM_REQ-1:0] r_timeout_err;

    logic [NUM_REQ-1:0] w_next_grant;
    logic [IDX_W-1:0]   w_next_idx;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_any_req;
    logic               w_valid_g;
    logic               w_last_g;
    logic               w_accept;
    logic               w_stall;
    logic               w_stall_expired;
    logic               w_drain_done;
    logic               w_release;

    uart_tx_arbiter_rr #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_req        (i_req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_next_grant)
    );

    always_comb begin
        w_next_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_next_grant[i]) w_next_idx = IDX_W'(i);
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_idx == IDX_W'(i)) w_sel_data = i_req_data[i*DATA_W +: DATA_W];
        end
    end

    assign w_any_req       = |i_req_valid;
    assign w_valid_g       = |(i_req_valid & r_grant);
    assign w_last_g        = |(i_req_last & r_grant);
    assign w_accept        = (r_state == ST_SEND) && w_valid_g && !i_tx_busy;
    assign w_stall         = (r_state == ST_SEND) && !w_valid_g;
    assign w_stall_expired = w_stall && (r_tmo_cnt == TMO_LAST);
    // The first DRAIN cycle is held because busy only rises a cycle after tx_start.
    assign w_drain_done    = (r_state == ST_DRAIN) && !r_drain_first && !i_tx_busy;
    assign w_release       = w_drain_done && r_last_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_req) w_state_nxt = ST_SEND;
            ST_SEND: begin
                if (w_accept)             w_state_nxt = ST_START;
                else if (w_stall_expired) w_state_nxt = ST_IDLE;
            end
            ST_START: w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_drain_done) w_state_nxt = r_last_q ? ST_IDLE : ST_SEND;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = '0;
        o_tx_start  = 1'b0;
        if (w_accept)              o_req_ready = r_grant;
        if (r_state == ST_START)   o_tx_start  = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_last_grant  <= IDX_W'(NUM_REQ - 1);
            r_tmo_cnt     <= '0;
            r_tx_data     <= '0;
            r_last_q      <= 1'b0;
            r_drain_first <= 1'b0;
            r_timeout_err <= '0;
        end else begin
            r_timeout_err <= '0;
            r_drain_first <= (r_state == ST_START);
            if ((r_state == ST_IDLE) && w_any_req) begin
                r_grant     <= w_next_grant;
                r_grant_idx <= w_next_idx;
                r_tmo_cnt   <= '0;
            end
            if (w_accept) begin
                r_tx_data <= w_sel_data;
                r_last_q  <= w_last_g;
                r_tmo_cnt <= '0;
            end else if (w_stall) begin
                if (w_stall_expired) begin
                    r_timeout_err <= r_grant;
                    r_grant       <= '0;
                    r_last_grant  <= r_grant_idx;
                end else if (r_tmo_cnt != '1) begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
            end
            if (w_release) begin
                r_grant      <= '0;
                r_last_grant <= r_grant_idx;
            end
        end
    end

    assign o_grant       = r_grant;
    assign o_tx_data     = r_tx_data;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a UART busy model
// (busy rises the cycle after tx_start and stays high 20 cycles).
module tb_uart_tx_arbiter;

    localparam int NR       = 4;
    localparam int DW       = 8;
    localparam int TMO      = 16;
    localparam int BUSY_CYC = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_ready;
    logic [DW-1:0]    tx_data;
    logic             tx_start;
    logic             tx_busy;
    logic [NR-1:0]    grant;
    logic [NR-1:0]    timeout_err;

    logic             force_busy;
    logic [4:0]       busy_cnt;

    always #10 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ     (NR),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .i_req_data    (req_data),
        .i_req_last    (req_last),
        .o_req_ready   (req_ready),
        .o_tx_data     (tx_data),
        .o_tx_start    (tx_start),
        .i_tx_busy     (tx_busy),
        .o_grant       (grant),
        .o_timeout_err (timeout_err)
    );

    always @(posedge clk) begin
        if (rst)                busy_cnt <= 5'd0;
        else if (tx_start)      busy_cnt <= 5'(BUSY_CYC);
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 5'd1;
    end
    assign tx_busy = force_busy | (busy_cnt != 5'd0);

    logic [7:0]    src_mem [NR][8];
    logic          src_lst [NR][8];
    int            src_len [NR];
    int            src_pos [NR];
    logic          rst_req, busy_req;
    logic [NR-1:0] ready_s;

    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc_cnt = 0;
    logic [7:0]    log_data [16];
    logic [NR-1:0] log_grant [16];
    int            log_t [16];
    int            log_n, tmo_n, tmo_t;
    logic [NR-1:0] tmo_val, tmo_grant, g_after, grant_or;
    int            rdy_n [NR];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            if (src_pos[i] < src_len[i]) begin
                req_valid[i]           = 1'b1;
                req_data[i*DW +: DW]   = src_mem[i][src_pos[i]];
                req_last[i]            = src_lst[i][src_pos[i]];
            end else begin
                req_valid[i]           = 1'b0;
                req_data[i*DW +: DW]   = '0;
                req_last[i]            = 1'b0;
            end
        end
    endtask

    // One clock: pop accepted bytes, drive inputs after the edge, sample at the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (ready_s[i]) src_pos[i]++;
        rst        = rst_req;
        force_busy = busy_req;
        drive_inputs();
        @(negedge clk);
        cyc_cnt++;
        ready_s  = req_ready;
        grant_or = grant_or | grant;
        for (int i = 0; i < NR; i++) rdy_n[i] += int'(req_ready[i]);
        if (tx_start && log_n < 16) begin
            log_data[log_n]  = tx_data;
            log_grant[log_n] = grant;
            log_t[log_n]     = cyc_cnt;
            log_n++;
        end
        if (timeout_err != '0) begin
            tmo_n++;
            tmo_t     = cyc_cnt;
            tmo_val   = timeout_err;
            tmo_grant = grant;
        end
        if (tmo_n > 0 && cyc_cnt == tmo_t + 1) g_after = grant;
    endtask

    task automatic load(input int r, input int n, input logic [63:0] bytes, input logic [7:0] lasts);
        for (int j = 0; j < 8; j++) begin
            src_mem[r][j] = bytes[j*8 +: 8];
            src_lst[r][j] = lasts[j];
        end
        src_len[r] = n;
        src_pos[r] = 0;
    endtask

    task automatic clear_logs();
        log_n = 0; tmo_n = 0; tmo_t = 0;
        tmo_val = '0; tmo_grant = '0; g_after = '0; grant_or = '0;
        for (int i = 0; i < NR; i++) rdy_n[i] = 0;
    endtask

    task automatic do_reset();
        rst_req  = 1'b1;
        busy_req = 1'b0;
        for (int i = 0; i < NR; i++) begin src_len[i] = 0; src_pos[i] = 0; end
        ready_s = '0;
        repeat (3) cyc();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_tx_start", 32'(tx_start), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_timeout_err", 32'(timeout_err), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        rst_req = 1'b0;
        cyc();
        clear_logs();
    endtask

    task automatic wait_done(input int budget, input string tag);
        int  k = 0;
        bit  done = 1'b0;
        bit  pend;
        while (!done && k < budget) begin
            cyc();
            k++;
            pend = 1'b0;
            for (int i = 0; i < NR; i++) if (src_pos[i] < src_len[i]) pend = 1'b1;
            done = !pend && (grant == '0) && !tx_start;
        end
        chk(tag, 32'(done), 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] e_data;
        logic [31:0] e_grant;
        int          k;
        rst = 1'b1; force_busy = 1'b0; rst_req = 1'b1; busy_req = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0; ready_s = '0;
        clear_logs();

        // 1: single three-byte packet from req0, with grant/start latency
        do_reset();
        load(0, 3, 64'h0A6948, 8'b100);
        cyc();
        chk("t1_grant_cyc_n", 32'(grant), 32'h0);
        cyc();
        chk("t1_grant_cyc_n1", 32'(grant), 32'h1);
        chk("t1_ready_cyc_n1", 32'(req_ready), 32'h1);
        cyc();
        chk("t1_start_cyc_n2", 32'(tx_start), 32'h1);
        chk("t1_data_cyc_n2", 32'(tx_data), 32'h48);
        wait_done(300, "t1_done");
        chk("t1_count", 32'(log_n), 32'd3);
        e_data = 32'h000A6948;
        for (int j = 0; j < 3; j++) begin
            chk("t1_tx_data", 32'(log_data[j]), 32'(e_data[j*8 +: 8]));
            chk("t1_tx_grant", 32'(log_grant[j]), 32'h1);
        end
        chk("t1_grant_or", 32'(grant_or), 32'h1);
        chk("t1_grant_end", 32'(grant), 32'h0);
        chk("t1_ready_cnt", 32'(rdy_n[0]), 32'd3);

        // 2: req0 and req2 together, no interleave
        do_reset();
        load(0, 2, 64'hA1A0, 8'b10);
        load(2, 2, 64'hC1C0, 8'b10);
        wait_done(300, "t2_done");
        chk("t2_count", 32'(log_n), 32'd4);
        e_data  = 32'hC1C0A1A0;
        e_grant = 32'h4411;
        for (int j = 0; j < 4; j++) begin
            chk("t2_tx_data", 32'(log_data[j]), 32'(e_data[j*8 +: 8]));
            chk("t2_tx_grant", 32'(log_grant[j]), 32'(e_grant[j*4 +: 4]));
        end

        // 3: all four offering one-byte packets, round-robin wrap
        do_reset();
        for (int i = 0; i < NR; i++) begin
            load(i, 2, 64'(((i + 1) << 12) | 32'h0100 | ((i + 1) << 4)), 8'b11);
        end
        wait_done(600, "t3_done");
        chk("t3_count", 32'(log_n), 32'd8);
        for (int j = 0; j < 8; j++) begin
            chk("t3_tx_grant", 32'(log_grant[j]), 32'(1 << (j % 4)));
            chk("t3_tx_data", 32'(log_data[j]), 32'((((j % 4) + 1) << 4) | (j / 4)));
        end

        // 4: req1 stalls mid-packet, watchdog frees the UART for req3
        do_reset();
        load(1, 1, 64'h55, 8'b0);
        load(3, 1, 64'h77, 8'b1);
        wait_done(300, "t4_done");
        chk("t4_count", 32'(log_n), 32'd2);
        chk("t4_first_data", 32'(log_data[0]), 32'h55);
        chk("t4_first_grant", 32'(log_grant[0]), 32'h2);
        chk("t4_tmo_pulses", 32'(tmo_n), 32'd1);
        chk("t4_tmo_value", 32'(tmo_val), 32'h2);
        chk("t4_tmo_grant_cleared", 32'(tmo_grant), 32'h0);
        chk("t4_tmo_delay_from_start", 32'(tmo_t - log_t[0]), 32'd38);
        chk("t4_grant_after_tmo", 32'(g_after), 32'h8);
        chk("t4_second_data", 32'(log_data[1]), 32'h77);
        chk("t4_second_grant", 32'(log_grant[1]), 32'h8);
        chk("t4_req1_ready_cnt", 32'(rdy_n[1]), 32'd1);

        // 5: reset in DRAIN abandons the packet; req0 wins after release
        do_reset();
        load(0, 1, 64'h99, 8'b1);
        k = 0;
        while (log_n == 0 && k < 10) begin cyc(); k++; end
        chk("t5_started", 32'(log_n), 32'd1);
        cyc();
        cyc();
        rst_req = 1'b1;
        clear_logs();
        load(0, 1, 64'hB0, 8'b1);
        load(1, 1, 64'hB1, 8'b1);
        ready_s = '0;
        cyc();
        cyc();
        chk("t5_rst_grant", 32'(grant), 32'h0);
        chk("t5_rst_tx_start", 32'(tx_start), 32'h0);
        chk("t5_rst_ready", 32'(req_ready), 32'h0);
        chk("t5_rst_no_start", 32'(log_n), 32'd0);
        rst_req = 1'b0;
        wait_done(300, "t5_done");
        chk("t5_count", 32'(log_n), 32'd2);
        chk("t5_first_grant", 32'(log_grant[0]), 32'h1);
        chk("t5_first_data", 32'(log_data[0]), 32'hB0);
        chk("t5_second_grant", 32'(log_grant[1]), 32'h2);
        chk("t5_second_data", 32'(log_data[1]), 32'hB1);

        // 6: UART busy at grant time; wait without timeout
        do_reset();
        busy_req = 1'b1;
        load(2, 1, 64'h3C, 8'b1);
        repeat (30) cyc();
        chk("t6_grant_held", 32'(grant), 32'h4);
        chk("t6_no_ready", 32'(rdy_n[2]), 32'd0);
        chk("t6_no_start", 32'(log_n), 32'd0);
        chk("t6_no_timeout", 32'(tmo_n), 32'd0);
        busy_req = 1'b0;
        cyc();
        chk("t6_ready_after_busy", 32'(req_ready), 32'h4);
        cyc();
        chk("t6_start_after_busy", 32'(tx_start), 32'h1);
        chk("t6_data_after_busy", 32'(tx_data), 32'h3C);
        wait_done(300, "t6_done");
        chk("t6_no_timeout_end", 32'(tmo_n), 32'd0);
        chk("t6_count", 32'(log_n), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
